// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: fetch FSM states,
// default widths and the instruction-register reset encoding.
package if_fetch_ctrl_pkg;

   localparam int          DW_DEF     = 32;
   localparam int          PC_INC_DEF = 4;
   localparam logic [31:0] NOP        = 32'h0000_0000;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      HOLD  = 3'd2,
      DRAIN = 3'd3,
      REDIR = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch bundle: pc register link, instruction-memory req/ack bus,
// decode valid/ready handshake and the redirect pulse.
interface if_fetch_ctrl_if
   import if_fetch_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF
);

   logic [DW-1:0] PC;
   logic [DW-1:0] PC_Next;
   logic          PC_LdEn;
   logic [DW-1:0] Imem_Addr;
   logic          Imem_Req;
   logic          Imem_Ack;
   logic [DW-1:0] Imem_Rdata;
   logic [DW-1:0] Instr;
   logic          InstrValid;
   logic          InstrReady;
   logic          Redirect;
   logic [DW-1:0] RedirectPC;

   // Fetch controller side
   modport master (
      input  PC, Imem_Ack, Imem_Rdata, InstrReady, Redirect, RedirectPC,
      output PC_Next, PC_LdEn, Imem_Addr, Imem_Req, Instr, InstrValid
   );

   // Environment side: pc register, instruction memory, decode, branch unit
   modport slave (
      output PC, Imem_Ack, Imem_Rdata, InstrReady, Redirect, RedirectPC,
      input  PC_Next, PC_LdEn, Imem_Addr, Imem_Req, Instr, InstrValid
   );

endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller for the multicycle MIPS datapath. Reads the PC,
// fetches one word over a req/ack bus, holds it for decode and advances the PC
// by PC_INC or to a redirect target. Redirects never cancel an outstanding
// memory request: the data is drained and dropped before the PC is reloaded.
module if_fetch_ctrl
   import if_fetch_ctrl_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int PC_INC = PC_INC_DEF
) (
   input  logic            Clk,
   input  logic            Reset,
   if_fetch_ctrl_if.master bus
);

   fetch_state_t  state, state_nxt;
   logic [DW-1:0] pending, pending_nxt;
   logic [DW-1:0] pc_next_r, pc_next_nxt;
   logic [DW-1:0] instr_r, instr_nxt;
   logic          ld_r, ld_nxt;
   logic          vld_r, vld_nxt;

   // The PC is stable whenever a request is up because no load happens in REQ/DRAIN.
   assign bus.Imem_Req   = (state == REQ) || (state == DRAIN);
   assign bus.Imem_Addr  = bus.PC;
   assign bus.PC_Next    = pc_next_r;
   assign bus.PC_LdEn    = ld_r;
   assign bus.Instr      = instr_r;
   assign bus.InstrValid = vld_r;

   // Latest redirect pulse wins, including one arriving in the cycle REDIR is entered.
   assign pending_nxt = bus.Redirect ? bus.RedirectPC : pending;

   // Next-state and registered-output decode; load enable is a one-cycle pulse.
   always_comb begin
      state_nxt   = state;
      pc_next_nxt = pc_next_r;
      instr_nxt   = instr_r;
      vld_nxt     = vld_r;
      ld_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (bus.Redirect) begin
               state_nxt   = REDIR;
               pc_next_nxt = pending_nxt;
               ld_nxt      = 1'b1;
            end else begin
               state_nxt = REQ;
            end
         end
         REQ: begin
            if (bus.Redirect) begin
               if (bus.Imem_Ack) begin
                  state_nxt   = REDIR;
                  pc_next_nxt = pending_nxt;
                  ld_nxt      = 1'b1;
               end else begin
                  state_nxt = DRAIN;
               end
            end else if (bus.Imem_Ack) begin
               state_nxt   = HOLD;
               instr_nxt   = bus.Imem_Rdata;
               vld_nxt     = 1'b1;
               pc_next_nxt = bus.PC + DW'(PC_INC);
               ld_nxt      = 1'b1;
            end
         end
         HOLD: begin
            if (bus.Redirect) begin
               state_nxt   = REDIR;
               vld_nxt     = 1'b0;
               pc_next_nxt = pending_nxt;
               ld_nxt      = 1'b1;
            end else if (bus.InstrReady) begin
               state_nxt = REQ;
               vld_nxt   = 1'b0;
            end
         end
         DRAIN: begin
            if (bus.Imem_Ack) begin
               state_nxt   = REDIR;
               pc_next_nxt = pending_nxt;
               ld_nxt      = 1'b1;
            end
         end
         REDIR: begin
            if (bus.Redirect) begin
               state_nxt   = REDIR;
               pc_next_nxt = pending_nxt;
               ld_nxt      = 1'b1;
            end else begin
               state_nxt = REQ;
            end
         end
         default: begin
            state_nxt = IDLE;
            vld_nxt   = 1'b0;
         end
      endcase
   end

   // State, pending target and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         pending   <= '0;
         pc_next_r <= '0;
         ld_r      <= 1'b0;
         instr_r   <= DW'(NOP);
         vld_r     <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         pc_next_r <= pc_next_nxt;
         ld_r      <= ld_nxt;
         instr_r   <= instr_nxt;
         vld_r     <= vld_nxt;
      end
   end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: provides the pc register, a variable-latency
// instruction memory, a decode stage and a branch unit, and compares the DUT
// every cycle with a transaction-level fetch model.
module tb_if_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic [31:0] pc;

   if_fetch_ctrl_if #(.DW(32)) ifc();

   if_fetch_ctrl #(.DW(32), .PC_INC(4)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (ifc)
   );

   always #5 Clk = ~Clk;

   // Architectural pc register
   always @(posedge Clk) begin
      if (Reset) pc <= 32'h0;
      else if (ifc.PC_LdEn) pc <= ifc.PC_Next;
   end
   assign ifc.PC = pc;

   int total = 0;
   int bad   = 0;

   // Model state: expected outputs for the coming cycle
   bit          m_req = 0, m_valid = 0, m_ld = 0, m_idle = 1, m_redc = 0;
   logic [31:0] m_instr = 0, m_pcnext = 0;
   bit          req_open = 0, squash = 0, redir_pend = 0;
   logic [31:0] req_addr = 0, tgt_l = 0, exp_pc = 0;

   // Stimulus controls
   int          lat_fix = 2;
   int          mem_cnt = 0;
   int          rdy_mode = 1;     // 0 random, 1 always ready, 2 never ready
   bit          rand_redir = 0;
   bit          f_redir = 0;
   logic [31:0] f_tgt = 0;

   // Observation logs (model values)
   int          cnt_valid, cnt_ld, cnt_req;
   logic [31:0] ld_q[$];
   logic [31:0] req_q[$];
   logic [31:0] ins_q[$];

   function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a == 32'h0) ? 32'h2008_0005 : ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
   endfunction

   function automatic int pick_lat();
      if (lat_fix >= 0) return lat_fix;
      return ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
   endfunction

   function automatic void clear_logs();
      cnt_valid = 0; cnt_ld = 0; cnt_req = 0;
      ld_q.delete(); req_q.delete(); ins_q.delete();
   endfunction

   // One clock: compare at negedge, drive next inputs, advance the model.
   task automatic cycle(input bit rst);
      bit          ack, rdy, rd, ack_eff, acc;
      bit          n_req, n_valid, n_ld, n_redc;
      logic [31:0] rdata, tgt, n_instr, n_pcn;
      @(negedge Clk);
      check("Imem_Req", {31'b0, ifc.Imem_Req}, {31'b0, m_req});
      check("InstrValid", {31'b0, ifc.InstrValid}, {31'b0, m_valid});
      check("PC_LdEn", {31'b0, ifc.PC_LdEn}, {31'b0, m_ld});
      check("Imem_Addr", ifc.Imem_Addr, pc);
      if (m_valid) check("Instr", ifc.Instr, m_instr);
      if (m_ld) check("PC_Next", ifc.PC_Next, m_pcnext);
      if (m_valid) cnt_valid++;
      if (m_ld) begin cnt_ld++; ld_q.push_back(m_pcnext); end
      if (m_req) cnt_req++;
      if (m_req && !req_open) begin
         req_open = 1; req_addr = pc; squash = 0; req_q.push_back(pc);
      end

      // memory slave, decode and branch unit
      ack = 0; rdata = $urandom;
      if (!rst && ifc.Imem_Req) begin
         if (mem_cnt == 0) begin ack = 1; rdata = mem_word(pc); mem_cnt = pick_lat(); end
         else mem_cnt--;
      end else if (!ifc.Imem_Req && $urandom_range(0, 3) == 0) ack = 1;
      rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      rd  = f_redir || (rand_redir && $urandom_range(0, 19) == 0);
      tgt = f_redir ? f_tgt :
            ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      f_redir = 0;
      Reset = rst;
      ifc.Imem_Ack = ack;
      ifc.Imem_Rdata = rdata;
      ifc.InstrReady = rdy;
      ifc.Redirect = rd && !rst;
      ifc.RedirectPC = rd ? tgt : $urandom;

      if (rst) begin
         m_req = 0; m_valid = 0; m_ld = 0; m_idle = 1; m_redc = 0;
         req_open = 0; squash = 0; redir_pend = 0; exp_pc = 0;
         mem_cnt = pick_lat();
         return;
      end

      ack_eff = m_req && ack;
      acc = m_valid && rdy;
      if (acc) ins_q.push_back(m_instr);
      if (rd) begin
         tgt_l = tgt; redir_pend = 1; exp_pc = tgt;
         if (req_open) squash = 1;
      end
      n_valid = m_valid; n_instr = m_instr; n_pcn = m_pcnext;
      n_ld = 0; n_req = m_req; n_redc = 0;
      if (m_valid && (rdy || rd)) n_valid = 0;
      if (ack_eff) begin
         req_open = 0; n_req = 0;
         if (!squash) begin
            check("fetch_pc", req_addr, exp_pc);
            n_valid = 1; n_instr = mem_word(req_addr);
            n_ld = 1; n_pcn = req_addr + 32'd4; exp_pc = n_pcn;
         end
      end
      if (redir_pend && (!m_req || ack_eff)) begin
         n_ld = 1; n_pcn = tgt_l; redir_pend = 0; n_redc = 1; n_req = 0;
      end else if (m_idle || m_redc || acc) begin
         n_req = 1;
      end
      m_req = n_req; m_valid = n_valid; m_instr = n_instr;
      m_ld = n_ld; m_pcnext = n_pcn; m_redc = n_redc; m_idle = 0;
   endtask

   initial begin
      int k, c80, c200;
      ifc.Imem_Ack = 0; ifc.Imem_Rdata = 0; ifc.InstrReady = 0;
      ifc.Redirect = 0; ifc.RedirectPC = 0;

      // Reset, latency 2, decode always ready
      lat_fix = 2; rdy_mode = 1;
      cycle(1); cycle(1);
      check("rst_Instr", ifc.Instr, 32'h0);
      check("rst_PC_Next", ifc.PC_Next, 32'h0);
      clear_logs();
      for (int i = 0; i < 8; i++) cycle(0);
      check("t1_instr", (ins_q.size() > 0) ? ins_q[0] : 32'hDEAD_BEEF, 32'h2008_0005);
      check("t1_valid_cycles", cnt_valid, 1);
      check("t1_ld_pc4", (ld_q.size() > 0) ? ld_q[0] : 32'hDEAD_BEEF, 32'h4);
      check("t1_next_addr", (req_q.size() > 1) ? req_q[1] : 32'hDEAD_BEEF, 32'h4);

      // Zero latency, decode stalls for 4 cycles then accepts
      lat_fix = 0; rdy_mode = 2;
      for (k = 0; k < 40 && !m_valid; k++) cycle(0);
      check("t2_wait_valid", {31'b0, m_valid}, 32'h1);
      clear_logs();
      for (int i = 0; i < 4; i++) cycle(0);
      rdy_mode = 1; cycle(0);
      rdy_mode = 2; cycle(0);
      check("t2_valid_cycles", cnt_valid, 5);
      check("t2_ld_pulses", cnt_ld, 1);
      check("t2_req_while_hold", cnt_req, 1);

      // Redirect at request start; memory answers 3 cycles late
      lat_fix = 3; rdy_mode = 1;
      for (k = 0; k < 40 && !(m_req && !req_open); k++) cycle(0);
      check("t3_wait_req", {31'b0, m_req}, 32'h1);
      mem_cnt = 3; clear_logs();
      f_redir = 1; f_tgt = 32'h40;
      for (int i = 0; i < 9; i++) cycle(0);
      check("t3_no_valid", cnt_valid, 0);
      check("t3_ld_target", (ld_q.size() > 0) ? ld_q[0] : 32'hDEAD_BEEF, 32'h40);
      check("t3_refetch_addr", (req_q.size() > 1) ? req_q[1] : 32'hDEAD_BEEF, 32'h40);
      check("t3_req_cycles", cnt_req, 8);

      // Redirect in HOLD, second redirect while in REDIR
      lat_fix = 0; rdy_mode = 2;
      for (k = 0; k < 40 && !m_valid; k++) cycle(0);
      check("t4_wait_valid", {31'b0, m_valid}, 32'h1);
      clear_logs();
      f_redir = 1; f_tgt = 32'h200; cycle(0);
      f_redir = 1; f_tgt = 32'h80;  cycle(0);
      rdy_mode = 1;
      for (int i = 0; i < 6; i++) cycle(0);
      c80 = 0; c200 = 0;
      foreach (req_q[i]) begin
         if (req_q[i] == 32'h80) c80++;
         if (req_q[i] == 32'h200) c200++;
      end
      check("t4_ld_first_redir", (ld_q.size() > 1) ? ld_q[1] : 32'hDEAD_BEEF, 32'h200);
      check("t4_ld_final_redir", (ld_q.size() > 2) ? ld_q[2] : 32'hDEAD_BEEF, 32'h80);
      check("t4_first_fetch", (req_q.size() > 0) ? req_q[0] : 32'hDEAD_BEEF, 32'h80);
      check("t4_fetches_80", c80, 1);
      check("t4_fetches_200", c200, 0);

      // PC wrap at the top of the address space
      lat_fix = 1; rdy_mode = 2;
      for (k = 0; k < 40 && !m_valid; k++) cycle(0);
      check("t5_wait_valid", {31'b0, m_valid}, 32'h1);
      f_redir = 1; f_tgt = 32'hFFFF_FFFC; cycle(0);
      clear_logs(); rdy_mode = 1;
      for (int i = 0; i < 6; i++) cycle(0);
      check("t5_ld_top", (ld_q.size() > 0) ? ld_q[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      check("t5_ld_wrap", (ld_q.size() > 1) ? ld_q[1] : 32'hDEAD_BEEF, 32'h0);
      check("t5_next_addr", (req_q.size() > 1) ? req_q[1] : 32'hDEAD_BEEF, 32'h0);

      // Reset in the middle of a request
      lat_fix = 5; rdy_mode = 1;
      for (k = 0; k < 40 && !(m_req && !req_open); k++) cycle(0);
      check("t6_wait_req", {31'b0, m_req}, 32'h1);
      mem_cnt = 5;
      cycle(0); cycle(0); cycle(1);
      @(posedge Clk); #1;
      check("t6_req_low", {31'b0, ifc.Imem_Req}, 32'h0);
      check("t6_valid_low", {31'b0, ifc.InstrValid}, 32'h0);
      check("t6_ld_low", {31'b0, ifc.PC_LdEn}, 32'h0);
      check("t6_pcnext_zero", ifc.PC_Next, 32'h0);
      check("t6_instr_zero", ifc.Instr, 32'h0);
      cycle(0);
      @(posedge Clk); #1;
      check("t6_req_resumes", {31'b0, ifc.Imem_Req}, 32'h1);

      // Random traffic
      lat_fix = -1; rdy_mode = 0; rand_redir = 1;
      for (int i = 0; i < 3000; i++) cycle(0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
